// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory access controller: turns EX/MEM load/store requests into
// handshaked bus transactions, stalls the pipeline until completion, returns extended load data.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exmem_mem_r,
    input  logic        exmem_mem_w,
    input  logic [31:0] exmem_addr,
    input  logic [1:0]  exmem_size,
    input  logic        exmem_load_signed,
    input  logic [31:0] exmem_wdata,
    output logic        mem_stall,
    output logic [31:0] mem_data,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  tmo_cnt;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [1:0]  lat_off;

    logic        req_any;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;

    always_comb begin
        req_any    = exmem_mem_r | exmem_mem_w;
        is_byte    = (exmem_size == 2'd0);
        is_half    = (exmem_size == 2'd1);
        is_word    = exmem_size[1];
        misaligned = (is_half & exmem_addr[0]) | (is_word & (|exmem_addr[1:0]));
        addr_err   = req_any & misaligned;
        mem_stall  = req_any & ~addr_err & (state != DONE);
    end

    // Lane enables and lane-replicated store data for the request being launched
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = exmem_wdata;
        if (is_byte) begin
            be_next    = 4'b0001 << exmem_addr[1:0];
            wdata_next = {4{exmem_wdata[7:0]}};
        end else if (is_half) begin
            be_next    = exmem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{exmem_wdata[15:0]}};
        end
    end

    // Extension uses the latched size/sign/offset so upstream changes during BUSY are harmless
    always_comb begin
        case (lat_off)
            2'd0:    byte_lane = dbus_rdata[7:0];
            2'd1:    byte_lane = dbus_rdata[15:8];
            2'd2:    byte_lane = dbus_rdata[23:16];
            default: byte_lane = dbus_rdata[31:24];
        endcase
        half_lane = lat_off[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        if (lat_size == 2'd0) begin
            load_ext = {{24{lat_signed & byte_lane[7]}}, byte_lane};
        end else if (lat_size == 2'd1) begin
            load_ext = {{16{lat_signed & half_lane[15]}}, half_lane};
        end else begin
            load_ext = dbus_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            lat_size   <= '0;
            lat_signed <= 1'b0;
            lat_off    <= '0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_be    <= '0;
            dbus_wdata <= '0;
            mem_data   <= '0;
            bus_err    <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any && !misaligned) begin
                        state      <= BUSY;
                        tmo_cnt    <= '0;
                        dbus_req   <= 1'b1;
                        dbus_we    <= exmem_mem_w;
                        dbus_addr  <= {exmem_addr[31:2], 2'b00};
                        dbus_be    <= be_next;
                        dbus_wdata <= wdata_next;
                        lat_size   <= exmem_size;
                        lat_signed <= exmem_load_signed;
                        lat_off    <= exmem_addr[1:0];
                    end
                end
                BUSY: begin
                    // An ack in the timeout cycle still completes the access normally
                    if (dbus_ack) begin
                        state    <= DONE;
                        dbus_req <= 1'b0;
                        mem_data <= dbus_we ? 32'd0 : load_ext;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= DONE;
                        dbus_req <= 1'b0;
                        bus_err  <= 1'b1;
                        mem_data <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl, built with TIMEOUT=4 so the
// timeout path is reachable in a handful of cycles.
module tb_dmem_ctrl;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        exmem_mem_r;
    logic        exmem_mem_w;
    logic [31:0] exmem_addr;
    logic [1:0]  exmem_size;
    logic        exmem_load_signed;
    logic [31:0] exmem_wdata;
    logic        mem_stall;
    logic [31:0] mem_data;
    logic        addr_err;
    logic        bus_err;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    int checks = 0;
    int errors = 0;

    dmem_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .exmem_mem_r       (exmem_mem_r),
        .exmem_mem_w       (exmem_mem_w),
        .exmem_addr        (exmem_addr),
        .exmem_size        (exmem_size),
        .exmem_load_signed (exmem_load_signed),
        .exmem_wdata       (exmem_wdata),
        .mem_stall         (mem_stall),
        .mem_data          (mem_data),
        .addr_err          (addr_err),
        .bus_err           (bus_err),
        .dbus_req          (dbus_req),
        .dbus_we           (dbus_we),
        .dbus_addr         (dbus_addr),
        .dbus_be           (dbus_be),
        .dbus_wdata        (dbus_wdata),
        .dbus_ack          (dbus_ack),
        .dbus_rdata        (dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        exmem_mem_r       = 1'b0;
        exmem_mem_w       = 1'b0;
        exmem_addr        = 32'd0;
        exmem_size        = 2'd0;
        exmem_load_signed = 1'b0;
        exmem_wdata       = 32'd0;
        dbus_ack          = 1'b0;
        dbus_rdata        = 32'd0;
    endtask

    // One access from request cycle 0 to the idle cycle after DONE; ackCyc=0 means no ack.
    // Called just after a rising edge; returns just after a rising edge.
    task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] wdata, input int ackCyc, input logic [31:0] rdata,
                                 input logic [31:0] expData, input logic expBerr,
                                 input logic [3:0] expBe, input logic [31:0] expWdata);
        int doneCyc;
        doneCyc = (ackCyc > 0) ? ackCyc + 1 : TB_TIMEOUT + 1;
        exmem_mem_r       = rd;
        exmem_mem_w       = wr;
        exmem_addr        = addr;
        exmem_size        = size;
        exmem_load_signed = sgn;
        exmem_wdata       = wdata;
        for (int c = 0; c <= doneCyc; c++) begin
            dbus_ack   = (c == ackCyc) && (c > 0);
            dbus_rdata = dbus_ack ? rdata : 32'h5A5A_5A5A;
            if (c == 2) begin
                exmem_addr        = addr ^ 32'h0000_1000;
                exmem_wdata       = ~wdata;
                exmem_load_signed = ~sgn;
            end
            @(negedge clk);
            checkOutput({name, " stall"}, 32'(mem_stall), 32'(c < doneCyc));
            checkOutput({name, " req"}, 32'(dbus_req), 32'((c >= 1) && (c < doneCyc)));
            if (c == doneCyc - 1) begin
                checkOutput({name, " be"}, 32'(dbus_be), 32'(expBe));
                checkOutput({name, " addr"}, dbus_addr, {addr[31:2], 2'b00});
                checkOutput({name, " wdata"}, dbus_wdata, expWdata);
                checkOutput({name, " we"}, 32'(dbus_we), 32'(wr));
            end
            if (c == doneCyc) begin
                checkOutput({name, " data"}, mem_data, expData);
                checkOutput({name, " berr"}, 32'(bus_err), 32'(expBerr));
            end
            @(posedge clk);
            #1;
        end
        idleInputs();
        @(negedge clk);
        checkOutput({name, " idle berr"}, 32'(bus_err), 32'd0);
        checkOutput({name, " idle req"}, 32'(dbus_req), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic misalignedCheck(input string name, input logic rd, input logic wr,
                                   input logic [31:0] addr, input logic [1:0] size,
                                   input logic [31:0] keptData);
        exmem_mem_r = rd;
        exmem_mem_w = wr;
        exmem_addr  = addr;
        exmem_size  = size;
        exmem_wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput({name, " aerr"}, 32'(addr_err), 32'd1);
            checkOutput({name, " stall"}, 32'(mem_stall), 32'd0);
            checkOutput({name, " req"}, 32'(dbus_req), 32'd0);
            checkOutput({name, " data"}, mem_data, keptData);
            @(posedge clk);
            #1;
        end
        idleInputs();
    endtask

    initial begin
        idleInputs();
        reset = 1'b0;
        #2;
        checkOutput("rst req", 32'(dbus_req), 32'd0);
        checkOutput("rst data", mem_data, 32'd0);
        checkOutput("rst addr", dbus_addr, 32'd0);
        checkOutput("rst stall", 32'(mem_stall), 32'd0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("wload", 1'b1, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 3, 32'hDEAD_BEEF,
                      32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0);
        applyStimulus("sbload", 1'b1, 1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 1, 32'h80FF_0000,
                      32'hFFFF_FF80, 1'b0, 4'b1000, 32'h0);
        applyStimulus("ubload", 1'b1, 1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 1, 32'h80FF_0000,
                      32'h0000_0080, 1'b0, 4'b1000, 32'h0);
        applyStimulus("hstore", 1'b0, 1'b1, 32'h202, 2'd1, 1'b0, 32'h1234_ABCD, 2, 32'h0,
                      32'h0, 1'b0, 4'b1100, 32'hABCD_ABCD);
        applyStimulus("bstore", 1'b1, 1'b1, 32'h001, 2'd0, 1'b0, 32'hFFFF_FF5A, 2, 32'h0,
                      32'h0, 1'b0, 4'b0010, 32'h5A5A_5A5A);
        applyStimulus("shload", 1'b1, 1'b0, 32'h102, 2'd1, 1'b1, 32'h0, 2, 32'h8001_1234,
                      32'hFFFF_8001, 1'b0, 4'b1100, 32'h0);

        misalignedCheck("mis wload", 1'b1, 1'b0, 32'h101, 2'd2, 32'hFFFF_8001);
        misalignedCheck("mis hstore", 1'b0, 1'b1, 32'h003, 2'd1, 32'hFFFF_8001);

        // Stray ack while idle must be ignored
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h1111_2222;
        @(negedge clk);
        checkOutput("idle ack req", 32'(dbus_req), 32'd0);
        @(posedge clk);
        #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        checkOutput("idle ack data", mem_data, 32'hFFFF_8001);
        checkOutput("idle ack berr", 32'(bus_err), 32'd0);
        @(posedge clk);
        #1;

        applyStimulus("timeout", 1'b1, 1'b0, 32'h300, 2'd2, 1'b0, 32'h0, 0, 32'h0,
                      32'h0, 1'b1, 4'b1111, 32'h0);
        applyStimulus("ack@tmo", 1'b1, 1'b0, 32'h304, 2'd3, 1'b0, 32'h0, TB_TIMEOUT, 32'h1234_5678,
                      32'h1234_5678, 1'b0, 4'b1111, 32'h0);

        // Reset in the second BUSY cycle of a word store
        exmem_mem_w = 1'b1;
        exmem_addr  = 32'h404;
        exmem_size  = 2'd2;
        exmem_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("prerst req", 32'(dbus_req), 32'd1);
        checkOutput("prerst we", 32'(dbus_we), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midrst req", 32'(dbus_req), 32'd0);
        checkOutput("midrst we", 32'(dbus_we), 32'd0);
        checkOutput("midrst addr", dbus_addr, 32'd0);
        checkOutput("midrst be", 32'(dbus_be), 32'd0);
        checkOutput("midrst wdata", dbus_wdata, 32'd0);
        checkOutput("midrst data", mem_data, 32'd0);
        idleInputs();
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h7777_7777;
        @(negedge clk);
        checkOutput("postrst stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        checkOutput("postrst req", 32'(dbus_req), 32'd0);
        checkOutput("postrst data", mem_data, 32'd0);
        checkOutput("postrst berr", 32'(bus_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
